// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared constants for the pipeline stall controller: stall vectors, stop flags, reset level
// and the multi-cycle sequencer state encodings.
package pipe_stall_ctrl_pkg;

  typedef logic [5:0] stall_vec_t;

  localparam stall_vec_t StallNone = 6'b000000;
  localparam stall_vec_t StallId   = 6'b000111;
  localparam stall_vec_t StallEx   = 6'b001111;

  localparam logic Stop      = 1'b1;
  localparam logic NoStop    = 1'b0;
  localparam logic RstEnable = 1'b1;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

endpackage

// File: rtl/pipe_stall_ctrl_multi_cycle_seq.sv
// Sequencer for multi-cycle EX operations: holds EX for N extra cycles, exposes the step
// index and a done pulse in the final EX cycle.
module pipe_stall_ctrl_multi_cycle_seq
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_multi_start,
  input  logic [CNT_W-1:0] ex_multi_cycles,
  input  logic             ex_multi_annul,
  output logic             ex_stall,
  output logic             ex_busy,
  output logic             ex_done,
  output logic [CNT_W-1:0] ex_cnt
);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] n_lat_q, n_lat_d;

  logic             stall_raw, busy_raw, done_raw;
  logic [CNT_W-1:0] cnt_raw;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      n_lat_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_lat_q <= n_lat_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    n_lat_d   = n_lat_q;
    stall_raw = NoStop;
    busy_raw  = 1'b0;
    done_raw  = 1'b0;
    cnt_raw   = '0;
    unique case (state_q)
      StIdle: begin
        // N=0 is an ordinary single-cycle op and never enters RUN
        if (ex_multi_start && (ex_multi_cycles != '0)) begin
          busy_raw  = 1'b1;
          stall_raw = Stop;
          n_lat_d   = ex_multi_cycles;
          cnt_d     = CNT_W'(1);
          state_d   = StRun;
        end
      end
      StRun: begin
        busy_raw = 1'b1;
        cnt_raw  = cnt_q;
        if (ex_multi_annul) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q < n_lat_q) begin
          stall_raw = Stop;
          cnt_d     = cnt_q + CNT_W'(1);
        end else begin
          done_raw = 1'b1;
          state_d  = StIdle;
          cnt_d    = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are held low for the whole reset cycle, including a mid-sequence reset.
  assign ex_stall = (rst == RstEnable) ? NoStop : stall_raw;
  assign ex_busy  = (rst == RstEnable) ? 1'b0   : busy_raw;
  assign ex_done  = (rst == RstEnable) ? 1'b0   : done_raw;
  assign ex_cnt   = (rst == RstEnable) ? '0     : cnt_raw;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller: merges the ID-stage stall request with the multi-cycle EX
// sequencer into the 6-bit stall vector (bit0 pc .. bit5 WB).
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_from_id,
  input  logic             ex_multi_start,
  input  logic [CNT_W-1:0] ex_multi_cycles,
  input  logic             ex_multi_annul,
  output logic [5:0]       stall,
  output logic             ex_busy,
  output logic             ex_done,
  output logic [CNT_W-1:0] ex_cnt
);

  logic ex_stall;

  pipe_stall_ctrl_multi_cycle_seq #(
    .CNT_W (CNT_W)
  ) u_seq (
    .clk             (clk),
    .rst             (rst),
    .ex_multi_start  (ex_multi_start),
    .ex_multi_cycles (ex_multi_cycles),
    .ex_multi_annul  (ex_multi_annul),
    .ex_stall        (ex_stall),
    .ex_busy         (ex_busy),
    .ex_done         (ex_done),
    .ex_cnt          (ex_cnt)
  );

  always_comb begin
    stall = StallNone;
    if (rst == RstEnable) begin
      stall = StallNone;
    end else if (ex_stall == Stop) begin
      stall = StallEx;
    end else if (stallreq_from_id) begin
      stall = StallId;
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: directed scenarios plus random traffic against an
// instruction-level model of EX occupancy.
module tb_pipe_stall_ctrl;

  localparam int CNT_W = 6;

  typedef struct {
    logic [5:0]       stall;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             stallreq_from_id = 1'b0;
  logic             ex_multi_start = 1'b0;
  logic [CNT_W-1:0] ex_multi_cycles = '0;
  logic             ex_multi_annul = 1'b0;
  logic [5:0]       stall;
  logic             ex_busy;
  logic             ex_done;
  logic [CNT_W-1:0] ex_cnt;

  int total = 0;
  int bad = 0;
  exp_t exp_q[$];

  // Model: an instruction occupying EX for total_cyc+1 cycles; step is its current cycle.
  bit m_in_ex = 0;
  int m_total = 0;
  int m_step = 0;

  pipe_stall_ctrl #(
    .CNT_W (CNT_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stallreq_from_id (stallreq_from_id),
    .ex_multi_start   (ex_multi_start),
    .ex_multi_cycles  (ex_multi_cycles),
    .ex_multi_annul   (ex_multi_annul),
    .stall            (stall),
    .ex_busy          (ex_busy),
    .ex_done          (ex_done),
    .ex_cnt           (ex_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  // One cycle of stimulus; the expected response is queued for the monitor.
  task automatic drive(input bit r, input bit id, input bit st, input int n, input bit an);
    exp_t e;
    bit   hold_ex;
    @(posedge clk);
    #1;
    rst              = r;
    stallreq_from_id = id;
    ex_multi_start   = st;
    ex_multi_cycles  = CNT_W'(n);
    ex_multi_annul   = an;
    e.busy = 0;
    e.done = 0;
    e.cnt  = '0;
    hold_ex = 0;
    if (r) begin
      m_in_ex = 0;
      e.stall = 6'b000000;
    end else begin
      if (m_in_ex) begin
        e.busy = 1;
        e.cnt  = CNT_W'(m_step);
        if (an) begin
          m_in_ex = 0;
        end else if (m_step == m_total) begin
          e.done  = 1;
          m_in_ex = 0;
        end else begin
          hold_ex = 1;
          m_step++;
        end
      end else if (st && n > 0) begin
        e.busy  = 1;
        hold_ex = 1;
        m_in_ex = 1;
        m_total = n;
        m_step  = 1;
      end
      e.stall = hold_ex ? 6'b001111 : (id ? 6'b000111 : 6'b000000);
    end
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("stall", int'(stall), int'(e.stall));
      check("ex_busy", int'(ex_busy), int'(e.busy));
      check("ex_done", int'(ex_done), int'(e.done));
      check("ex_cnt", int'(ex_cnt), int'(e.cnt));
    end
  end

  initial begin
    int r_n;
    // Reset and idle
    repeat (2) drive(1, 0, 0, 0, 0);
    repeat (3) drive(0, 0, 0, 0, 0);
    // ID request alone
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    // N=0 start is single-cycle
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0);
    // N=2, cycles input changed mid-run
    drive(0, 0, 1, 2, 0);
    drive(0, 0, 1, 7, 0);
    drive(0, 0, 1, 7, 0);
    drive(0, 0, 0, 0, 0);
    // N=32 with ID request throughout
    repeat (33) drive(0, 1, 1, 32, 0);
    drive(0, 0, 0, 0, 0);
    // N=10 annulled at step 4 while ID requests
    repeat (4) drive(0, 0, 1, 10, 0);
    drive(0, 1, 1, 10, 1);
    drive(0, 0, 0, 0, 0);
    // Back-to-back N=1 instructions with start held high
    repeat (4) drive(0, 0, 1, 1, 0);
    drive(0, 0, 0, 0, 0);
    // Reset at step 5 of an N=32 sequence
    repeat (5) drive(0, 0, 1, 32, 0);
    drive(1, 0, 1, 32, 0);
    drive(0, 0, 0, 0, 0);
    // Maximum N
    repeat (64) drive(0, 0, 1, 63, 0);
    drive(0, 0, 0, 0, 0);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      r_n = $urandom_range(0, 9);
      if (r_n == 0) r_n = 0;
      else if (r_n == 1) r_n = 63;
      else r_n = $urandom_range(1, 5);
      drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 30),
            ($urandom_range(0, 99) < 40), r_n, ($urandom_range(0, 99) < 5));
    end
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Pipeline control unit that produces the 6-bit stall vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb. It merges the ID-stage load-use stall request with a sequencer for multi-cycle EX operations, such as madd/msub (2 cycles) and div (33+ cycles). It holds the EX instruction in place for a programmed number of extra cycles and provides a step counter and a done pulse to the EX datapath.

Parameters:
CNT_W, 6, width of the extra-cycle request and the step counter (max 2^CNT_W-1 extra cycles)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
stallreq_from_id  input  1  ID-stage stall request (load-use or similar)
ex_multi_start  input  1  EX holds a multi-cycle instruction; level, held high until it leaves EX
ex_multi_cycles  input  CNT_W  extra EX cycles N required by that instruction; sampled only at start
ex_multi_annul  input  1  cancel the running sequence (exception or flush)
stall  output  6  stall vector; bit0 pc, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = Stop
ex_busy  output  1  multi-cycle sequence active (combinational)
ex_done  output  1  one-cycle pulse in the final EX cycle of a sequence
ex_cnt  output  CNT_W  current step index 0..N for the EX datapath

Behaviour:
- State machine: IDLE, RUN. Registers: state, cnt, n_lat (CNT_W).
- Reset (rst=1 at posedge): state=IDLE, cnt=0, n_lat=0.
  - While rst is high, all outputs are forced low: stall=6'b000000, ex_busy=0, ex_done=0, ex_cnt=0.
- IDLE:
  - ex_multi_start=1 and ex_multi_cycles=N>0 (cycle 0): ex_busy=1, ex_cnt=0, EX stall asserted this cycle. Next: n_lat<=N, cnt<=1, state<=RUN.
  - ex_multi_start=1 and N=0: single-cycle operation. No stall from EX, no state change, ex_done=0.
  - ex_multi_annul in IDLE: ignored.
- RUN:
  - ex_cnt=cnt and ex_busy=1.
  - cnt<n_lat: EX stall asserted, cnt<=cnt+1.
  - cnt==n_lat: ex_done=1, EX stall deasserted so the instruction advances this edge, state<=IDLE, cnt<=0.
  - ex_multi_start and ex_multi_cycles are ignored during RUN, including the done cycle; the same instruction keeps start high.
  - ex_multi_annul=1: state<=IDLE and cnt<=0 next cycle. EX stall is deasserted this cycle and ex_done=0. Annul has priority over done.
- Total EX occupancy for an instruction is N+1 cycles.
- A new start in the cycle after done comes from the next instruction and begins a fresh sequence.
- Stall vector, in priority order (combinational):
  - EX stall active: stall=6'b001111. This covers the ID request.
  - Else stallreq_from_id=1: stall=6'b000111. id_ex then inserts a bubble.
  - Else: stall=6'b000000.
- stall[4] and stall[5] are always 0 in this block.
- The counter never wraps: cnt is bounded by n_lat, and N=2^CNT_W-1 is legal.
- Reset mid-RUN aborts immediately with no done pulse.

Decomposition:
- Shared defines.v additions:
  - stall vector constants: STALL_NONE 6'b000000, STALL_ID 6'b000111, STALL_EX 6'b001111.
  - state encodings for IDLE and RUN.
- Existing Stop/NoStop and RstEnable constants are reused.
- One optional sub-module, multi_cycle_seq: holds the FSM, counter and n_lat, and outputs ex_stall, ex_busy, ex_done and ex_cnt.
- The top level does only the priority merge into stall.

Test Plan:
- Reset, then idle inputs -> stall=000000, ex_busy=0, ex_cnt=0 for 3 cycles. Assert rst mid-RUN at cnt=5 with N=32 -> next cycle state IDLE, stall=000000, no ex_done.
- stallreq_from_id=1 for 1 cycle, no start -> stall=000111 that cycle only. id_ex shows NOP aluop next edge.
- start=1 with N=0 for 1 cycle -> stall=000000, ex_busy=0, ex_done=0.
- start=1 with N=2 -> expected by cycle:
  - c0: stall=001111, ex_cnt=0.
  - c1: stall=001111, ex_cnt=1.
  - c2: stall=000000, ex_cnt=2, ex_done=1.
  - c3: IDLE.
  - Change ex_multi_cycles to 7 at c1 -> no effect.
- start=1 with N=32, stallreq_from_id=1 throughout -> stall=001111 for 32 cycles. At cnt=32, ex_done=1 and stall=000111.
- Annul and back-to-back:
  - N=10, annul at cnt=4 -> that cycle stall=000000 (or 000111 if ID requests) and ex_done=0; IDLE next cycle.
  - Separate run: start held high across two consecutive N=1 instructions -> done at c1, new sequence begins at c2 with stall=001111, done at c3.
